// File: rtl/multicycle_seq.sv
// multicycle_seq: multicycle RV64I sequencer with fetch/data port arbitration, bus timeout and trap entry
module multicycle_seq #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_is_fetch,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ir,
  input  logic        branch_taken,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state_o
);
  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6
  } state_t;
  typedef enum logic [3:0] {
    C_R, C_R32, C_IARITH, C_I32, C_LOAD, C_STORE, C_BRANCH,
    C_JAL, C_JALR, C_LUI, C_AUIPC, C_SYSTEM, C_ILLEGAL
  } cls_t;
  state_t      state_q, state_d;
  cls_t        cls_q, cls_d, opc_cls;
  logic [31:0] ir_q, ir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  cause_q, cause_d;
  logic        mem_busy, timeout, is_jump;
  always_comb begin
    case (ir_q[6:0])
      7'b0110011: opc_cls = C_R;
      7'b0111011: opc_cls = C_R32;
      7'b0010011: opc_cls = C_IARITH;
      7'b0011011: opc_cls = C_I32;
      7'b0000011: opc_cls = C_LOAD;
      7'b0100011: opc_cls = C_STORE;
      7'b1100011: opc_cls = C_BRANCH;
      7'b1101111: opc_cls = C_JAL;
      7'b1100111: opc_cls = C_JALR;
      7'b0110111: opc_cls = C_LUI;
      7'b0010111: opc_cls = C_AUIPC;
      7'b1110011: opc_cls = C_SYSTEM;
      default:    opc_cls = C_ILLEGAL;
    endcase
  end
  assign mem_busy = state_q == S_FETCH || state_q == S_MEM;
  // the increment would reach the limit this cycle; a same-cycle ack takes priority
  assign timeout  = mem_busy && !mem_ack && cnt_q == CW'(MEM_TIMEOUT - 1);
  assign is_jump  = cls_q inside {C_JAL, C_JALR};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_ack ? S_DECODE : timeout ? S_TRAP : S_FETCH;
      S_DECODE: state_d = opc_cls inside {C_ILLEGAL, C_SYSTEM} ? S_TRAP : S_EXEC;
      S_EXEC:   state_d = cls_q inside {C_BRANCH, C_JAL, C_JALR} ? S_FETCH :
                          cls_q inside {C_LOAD, C_STORE} ? S_MEM : S_WB;
      S_MEM:    state_d = mem_ack ? (cls_q == C_LOAD ? S_WB : S_FETCH) : timeout ? S_TRAP : S_MEM;
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'b00;
    rf_we        = 1'b0;
    wb_sel       = 2'b00;
    trap         = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req      = 1'b1;
        mem_is_fetch = 1'b1;
      end
      S_EXEC: begin
        alu_a_sel = cls_q inside {C_AUIPC, C_BRANCH, C_JAL};
        alu_b_sel = !(cls_q inside {C_R, C_R32, C_BRANCH});
        pc_we     = cls_q == C_BRANCH || is_jump;
        pc_src    = cls_q == C_BRANCH ? {1'b0, branch_taken} :
                    cls_q == C_JAL ? 2'b01 : cls_q == C_JALR ? 2'b10 : 2'b00;
        rf_we     = is_jump;
        wb_sel    = is_jump ? 2'b10 : 2'b00;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = cls_q == C_STORE;
        pc_we   = mem_ack && cls_q == C_STORE;
      end
      S_WB: begin
        rf_we  = 1'b1;
        wb_sel = cls_q == C_LOAD ? 2'b01 : 2'b00;
        pc_we  = 1'b1;
      end
      S_TRAP: begin
        trap   = 1'b1;
        pc_we  = 1'b1;
        pc_src = 2'b11;
      end
      default: ;
    endcase
  end
  always_comb begin
    ir_d    = state_q == S_FETCH && mem_ack ? mem_rdata : ir_q;
    cls_d   = state_q == S_DECODE ? opc_cls : cls_q;
    cnt_d   = mem_busy && !mem_ack && !timeout ? cnt_q + 1'b1 : '0;
    cause_d = timeout ? 2'b10 :
              state_q == S_DECODE && opc_cls == C_ILLEGAL ? 2'b01 :
              state_q == S_DECODE && opc_cls == C_SYSTEM ? 2'b11 : cause_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q    <= '0;
      cls_q   <= C_ILLEGAL;
      cnt_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      ir_q    <= ir_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end
  assign ir         = ir_q;
  assign trap_cause = cause_q;
  assign state_o    = state_q;
endmodule

// File: tb/tb_multicycle_seq.sv
// tb_multicycle_seq: directed and random instruction streams checked against a per-instruction path model
module tb_multicycle_seq;
  localparam int TO = 4;
  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3, S_MEM = 4, S_WB = 5, S_TRAP = 6;
  localparam logic [6:0] OP_R = 7'b0110011, OP_R32 = 7'b0111011, OP_IA = 7'b0010011, OP_I32 = 7'b0011011,
    OP_LD = 7'b0000011, OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
    OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_SYS = 7'b1110011;
  logic        clk = 1'b0, rst_n = 1'b0, mem_ack = 1'b0, branch_taken = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_req, mem_we, mem_is_fetch, alu_a_sel, alu_b_sel, pc_we, rf_we, trap;
  logic [1:0]  pc_src, wb_sel, trap_cause;
  logic [2:0]  state_o;
  logic [31:0] ir;
  int checks = 0, fails = 0;
  logic [31:0] cur_ir = '0;
  logic [1:0]  cur_cause = 2'b00;
  int st_q[$];
  bit ack_q[$];
  logic [6:0] ops [12] = '{OP_R, OP_R32, OP_IA, OP_I32, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYS};

  multicycle_seq #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_is_fetch(mem_is_fetch),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir), .branch_taken(branch_taken),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we),
    .wb_sel(wb_sel), .trap(trap), .trap_cause(trap_cause), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string p);
    check({p, "_state"}, state_o, S_IDLE);
    check({p, "_mem_req"}, mem_req, 0);
    check({p, "_mem_we"}, mem_we, 0);
    check({p, "_mem_is_fetch"}, mem_is_fetch, 0);
    check({p, "_pc_we"}, pc_we, 0);
    check({p, "_rf_we"}, rf_we, 0);
    check({p, "_trap"}, trap, 0);
    check({p, "_pc_src"}, pc_src, 0);
    check({p, "_wb_sel"}, wb_sel, 0);
    check({p, "_alu_sel"}, {alu_a_sel, alu_b_sel}, 0);
    check({p, "_ir"}, ir, cur_ir);
    check({p, "_trap_cause"}, trap_cause, cur_cause);
  endtask

  // a request phase acks on its (w+1)-th cycle, or traps after TO unanswered cycles
  function automatic bit add_req(input int s, input int w);
    for (int k = 0; k < TO; k++) begin
      st_q.push_back(s);
      ack_q.push_back(k == w);
      if (k == w) return 1'b0;
    end
    st_q.push_back(S_TRAP);
    ack_q.push_back(1'b0);
    return 1'b1;
  endfunction

  task automatic release_reset();
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = $urandom;
    rst_n     = 1'b1;
    #1;
    check_quiet("idle");
  endtask

  task automatic run_instr(input logic [31:0] instr, input int fw, input int mw, input logic bt, input int abort_at);
    logic [6:0] op;
    bit ld, sto, br, jal, jalr, legal, tmo, wr;
    logic [1:0] tcause;
    int last;
    op = instr[6:0];
    ld = op == OP_LD; sto = op == OP_ST; br = op == OP_BR; jal = op == OP_JAL; jalr = op == OP_JALR;
    legal = op inside {OP_R, OP_R32, OP_IA, OP_I32, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYS};
    st_q.delete();
    ack_q.delete();
    tcause = 2'b10;
    tmo = add_req(S_FETCH, fw);
    if (!tmo) begin
      st_q.push_back(S_DECODE); ack_q.push_back(1'b0);
      if (!legal || op == OP_SYS) begin
        tcause = legal ? 2'b11 : 2'b01;
        st_q.push_back(S_TRAP); ack_q.push_back(1'b0);
      end else begin
        st_q.push_back(S_EXEC); ack_q.push_back(1'b0);
        if (ld || sto) begin
          if (!add_req(S_MEM, mw) && ld) begin st_q.push_back(S_WB); ack_q.push_back(1'b0); end
        end else if (!(br || jal || jalr)) begin
          st_q.push_back(S_WB); ack_q.push_back(1'b0);
        end
      end
    end
    last = st_q.size() - 1;
    for (int i = 0; i <= last; i++) begin
      int s;
      bit fin, tr;
      s = st_q[i];
      fin = i == last;
      tr = s == S_TRAP;
      @(negedge clk);
      mem_ack = ack_q[i] ? 1'b1 : (s != S_FETCH && s != S_MEM) ? 1'($urandom_range(1)) : 1'b0;
      mem_rdata = (ack_q[i] && s == S_FETCH) ? instr : $urandom;
      branch_taken = s == S_EXEC ? bt : 1'($urandom_range(1));
      if (tr) cur_cause = tcause;
      #1;
      wr = fin && !tr && !br && !sto;
      check("state", state_o, s);
      check("mem_req", mem_req, s == S_FETCH || s == S_MEM);
      check("mem_is_fetch", mem_is_fetch, s == S_FETCH);
      check("mem_we", mem_we, s == S_MEM && sto);
      check("ir", ir, cur_ir);
      check("trap_cause", trap_cause, cur_cause);
      check("trap", trap, tr);
      check("pc_we", pc_we, fin);
      check("rf_we", rf_we, wr);
      check("wb_sel", wb_sel, !wr ? 0 : ld ? 1 : (jal || jalr) ? 2 : 0);
      check("pc_src", pc_src, !fin ? 0 : tr ? 3 : br ? {1'b0, bt} : jal ? 1 : jalr ? 2 : 0);
      check("alu_a_sel", alu_a_sel, s == S_EXEC && (op == OP_AUIPC || br || jal));
      check("alu_b_sel", alu_b_sel, s == S_EXEC && !(op == OP_R || op == OP_R32 || br));
      if (s == S_FETCH && ack_q[i]) cur_ir = instr;
      if (i == abort_at) begin
        #1 rst_n = 1'b0;
        #1;
        cur_ir = '0;
        cur_cause = 2'b00;
        check("abort_mem_req", mem_req, 0);
        check_quiet("abort");
        repeat (2) begin
          @(negedge clk);
          mem_ack = 1'b1;
          mem_rdata = $urandom;
        end
        #1;
        check_quiet("stray_ack");
        release_reset();
        return;
      end
    end
  endtask

  initial begin
    mem_ack = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    #1;
    check_quiet("reset");
    release_reset();
    run_instr(32'h00500093, 0, 0, 1'b0, -1);
    run_instr(32'h0000B103, 0, 3, 1'b0, -1);
    run_instr(32'h00208463, 0, 0, 1'b1, -1);
    run_instr(32'h00208463, 1, 0, 1'b0, -1);
    run_instr(32'hFFFFFFFF, 0, 0, 1'b0, -1);
    run_instr(32'h00000073, 0, 0, 1'b0, -1);
    run_instr(32'h00500093, TO, 0, 1'b0, -1);
    run_instr(32'h00500093, TO - 1, 0, 1'b0, -1);
    run_instr(32'h0020B023, 0, TO, 1'b0, -1);
    run_instr(32'h0020B023, 2, 1, 1'b0, -1);
    run_instr(32'h008000EF, 0, 0, 1'b0, -1);
    run_instr(32'h000080E7, 0, 0, 1'b0, -1);
    run_instr(32'h0000B103, 0, TO, 1'b0, 4);
    for (int n = 0; n < 200; n++) begin
      logic [31:0] instr;
      int idx;
      instr = $urandom;
      idx = $urandom_range(0, 13);
      if (idx < 12) instr[6:0] = ops[idx];
      else while (instr[6:0] inside {OP_R, OP_R32, OP_IA, OP_I32, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYS})
        instr[6:0] = 7'($urandom);
      run_instr(instr, $urandom_range(0, TO), $urandom_range(0, TO), 1'($urandom_range(1)), n == 120 ? 2 : -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
